// File: rtl/bidir_switch_config_loader.sv
// bidir_switch_config_loader
//   Byte-serial configuration writer for bidir_switch_block. A framed stream
//   (HEADER, P0..P13 [, checksum]) is assembled into a 108-bit shadow word.
//   The shadow word is then committed atomically to 'select'.
//
//   Optional feature macro: CONFIG_CHECKSUM_EN
//     defined   -> a trailing XOR checksum byte is checked in the CHECK state;
//                  'err' pulses when the checksum does not match.
//     undefined -> no CHECK state and no XOR logic; COMMIT follows P13
//                  directly; 'err' is tied low.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_data    : configuration byte
//   in_valid   : in_data valid
//   in_ready   : loader accepts a byte (transfer on in_valid && in_ready)
//   cfg_clear  : synchronous clear; opens all switches, aborts any frame
//   select     : committed 108-bit switch configuration
//   busy       : frame in progress (PAYLOAD / CHECK / COMMIT)
//   done       : one-cycle pulse, new select committed
//   err        : one-cycle pulse, frame rejected (checksum build only)

module bidir_switch_config_loader #(
    parameter logic [7:0]     HEADER = 8'hA5,
    localparam int unsigned   SEL_W  = 108
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cfg_clear,
    output logic [SEL_W-1:0] select,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned LO_BYTES = 13;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(13);

`ifdef CONFIG_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        COMMIT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        COMMIT  = 2'd3
    } state_t;
`endif

    state_t state;
    state_t state_n;

    // Shadow word split into the 13 full bytes and the final nibble.
    logic [LO_BYTES-1:0][7:0] shadow_lo;
    logic [3:0]               shadow_hi;
    logic [CNT_W-1:0]         cnt;

    logic xfer;
    logic start_c;
    logic load_c;
    logic commit_c;
    logic done_c;

`ifdef CONFIG_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_c;
`endif

    // Ready is withheld only during COMMIT and while reset is asserted.
    assign in_ready = !rst && (state != COMMIT);
    assign xfer     = in_valid && in_ready;

    // Next-state and control decode.
    always_comb begin
        state_n  = state;
        start_c  = 1'b0;
        load_c   = 1'b0;
        commit_c = 1'b0;
        done_c   = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
        err_c    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Non-header bytes are dropped silently while hunting.
                if (xfer && (in_data == HEADER)) begin
                    start_c = 1'b1;
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    load_c = 1'b1;
                    if (cnt == LAST_IDX) begin
`ifdef CONFIG_CHECKSUM_EN
                        state_n = CHECK;
`else
                        state_n = COMMIT;
`endif
                    end
                end
            end
`ifdef CONFIG_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (in_data == csum) begin
                        state_n = COMMIT;
                    end else begin
                        err_c   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                commit_c = 1'b1;
                done_c   = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register; clear aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst || cfg_clear) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Shadow assembly, byte counter and committed select.
    always_ff @(posedge clk) begin
        if (rst || cfg_clear) begin
            shadow_lo <= '0;
            shadow_hi <= '0;
            cnt       <= '0;
            select    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_c;
            busy <= (state_n != IDLE);
            if (start_c) begin
                cnt <= '0;
            end else if (load_c) begin
                // Little-endian: Pk lands in bits [8k+7:8k]; P13 only its low nibble.
                if (cnt == LAST_IDX) begin
                    shadow_hi <= in_data[3:0];
                end else begin
                    shadow_lo[cnt] <= in_data;
                end
                cnt <= cnt + CNT_W'(1);
            end
            if (commit_c) begin
                select <= {shadow_hi, shadow_lo};
            end
        end
    end

`ifdef CONFIG_CHECKSUM_EN
    // Running XOR over the full payload bytes, including P13[7:4].
    always_ff @(posedge clk) begin
        if (rst || cfg_clear) begin
            csum <= 8'h00;
            err  <= 1'b0;
        end else begin
            err <= err_c;
            if (start_c) begin
                csum <= 8'h00;
            end else if (load_c) begin
                csum <= csum ^ in_data;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_switch_config_loader.sv
// Scoreboard bench for bidir_switch_config_loader: stimulus pushes expected
// commit/reject events into a queue; a monitor pops them whenever done/err
// pulses. Works in both builds (CONFIG_CHECKSUM_EN defined or not).

module tb_bidir_switch_config_loader;

    localparam int unsigned SEL_W = 108;

    typedef logic [13:0][7:0] frame_t;
    typedef struct packed {
        logic             is_err;
        logic [SEL_W-1:0] sel;
    } exp_t;

    localparam logic [SEL_W-1:0] SEL_ONES = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_BO   = 108'hD0C0B0A09080706050403020100;
    localparam logic [SEL_W-1:0] SEL_C    = 108'hEDDCCBBAA998877665544332211;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             cfg_clear;
    logic [SEL_W-1:0] select;
    logic             busy;
    logic             done;
    logic             err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    frame_t f_ones;
    frame_t f_bo;
    frame_t f_c;

    always #5 clk = ~clk;

    bidir_switch_config_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_clear (cfg_clear),
        .select    (select),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [SEL_W-1:0] act,
                         input logic [SEL_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

`ifdef CONFIG_CHECKSUM_EN
    function automatic logic [7:0] frame_ck(input frame_t p);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 14; k++) x = x ^ p[k];
        return x;
    endfunction
`endif

    task automatic expect_event(input logic is_err, input logic [SEL_W-1:0] sel);
        exp_t e;
        e.is_err = is_err;
        e.sel    = sel;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check1("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_payload(input frame_t p, input bit gaps);
        send_byte(8'hA5);
        for (int k = 0; k < 14; k++) begin
            if (gaps && ($urandom_range(0, 1) != 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_byte(p[k]);
        end
    endtask

    task automatic send_full(input frame_t p, input bit gaps);
        send_payload(p, gaps);
`ifdef CONFIG_CHECKSUM_EN
        send_byte(frame_ck(p));
`endif
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            check1("done_err_overlap", done & err, 1'b0);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check1("unexpected_event", done | err, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check1("event_kind", err, e.is_err);
                    check("event_select", select, e.sel);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 13; k++) begin
            f_ones[k] = 8'hFF;
            f_bo[k]   = 8'(k);
            f_c[k]    = 8'(8'h11 * (k + 1));
        end
        f_ones[13] = 8'h0F;
        f_bo[13]   = 8'hFD;
        f_c[13]    = 8'hEE;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cfg_clear = 1'b0;

        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_select", select, '0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("idle_in_ready", in_ready, 1'b1);
        check("idle_select", select, '0);
        check1("idle_busy", busy, 1'b0);

        // All-ones frame with commit latency and in_ready bubble.
        expect_event(1'b0, SEL_ONES);
        send_full(f_ones, 1'b0);
        check1("commit_in_ready_low", in_ready, 1'b0);
        check1("commit_busy", busy, 1'b1);
        check1("commit_done_not_yet", done, 1'b0);
        @(negedge clk);
        check1("after_commit_done", done, 1'b1);
        check1("after_commit_in_ready", in_ready, 1'b1);
        check1("after_commit_busy", busy, 1'b0);

        // Byte ordering.
        expect_event(1'b0, SEL_BO);
        send_full(f_bo, 1'b0);
        @(negedge clk);

`ifdef CONFIG_CHECKSUM_EN
        // Wrong checksum: reject, keep select, then a good frame commits.
        expect_event(1'b1, SEL_BO);
        send_payload(f_bo, 1'b0);
        send_byte(8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        check("bad_ck_select_kept", select, SEL_BO);
        expect_event(1'b0, SEL_ONES);
        send_full(f_ones, 1'b0);
        @(negedge clk);
`endif

        // Garbage before header, then gap-free vs gapped frames.
        send_byte(8'h3C);
        check1("garbage_err", err, 1'b0);
        send_byte(8'h00);
        check1("garbage_err2", err, 1'b0);
        check1("garbage_busy", busy, 1'b0);
        expect_event(1'b0, SEL_C);
        send_full(f_c, 1'b0);
        @(negedge clk);
        expect_event(1'b0, SEL_ONES);
        send_full(f_ones, 1'b0);
        @(negedge clk);
        expect_event(1'b0, SEL_C);
        send_full(f_c, 1'b1);
        @(negedge clk);
        check("gapped_select", select, SEL_C);

        // cfg_clear on the COMMIT edge beats the commit.
        send_full(f_bo, 1'b0);
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
        check("clear_select", select, '0);
        check1("clear_done", done, 1'b0);
        check1("clear_busy", busy, 1'b0);

        // Reset after P6 discards the frame; the next frame commits.
        expect_event(1'b0, SEL_ONES);
        send_full(f_ones, 1'b0);
        @(negedge clk);
        send_byte(8'hA5);
        for (int k = 0; k < 7; k++) send_byte(f_bo[k]);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_select", select, '0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        expect_event(1'b0, SEL_BO);
        send_full(f_bo, 1'b0);
        @(negedge clk);

        repeat (4) @(negedge clk);
        check("queue_empty", SEL_W'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
